// File: rtl/rh_pkg.sv
// Shared definitions for the RH11-style interrupt arbiter: FSM encoding,
// CS1 bit positions and the default RH11 interrupt vector.
package rh_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } rh_state_e;

    localparam int CS1_RDY_BIT = 7;
    localparam int CS1_IE_BIT  = 6;

    localparam logic [7:0] RH_VEC_DEFAULT = 8'o254;

endpackage

// File: rtl/rh_intr_chan.sv
// One RH11-style interrupt channel: RDY edge detector, interrupt flip-flop
// (clear wins over set) and the combined edge/level request.
module rh_intr_chan (
    input  logic clk,
    input  logic rst,
    input  logic dev_reset,
    input  logic wr_set,
    input  logic rdy,
    input  logic ie,
    input  logic sc,
    input  logic clr,
    input  logic ack,
    output logic req
);

    logic last_rdy_q, last_rdy_d;
    logic iff_q, iff_d;
    logic set_ev, clr_ev;

    always_comb begin
        set_ev     = (rdy & ~last_rdy_q & ie) | wr_set;
        clr_ev     = dev_reset | clr | ack;
        last_rdy_d = rdy;
        iff_d      = iff_q;
        if (clr_ev) begin
            iff_d = 1'b0;
        end else if (set_ev) begin
            iff_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_rdy_q <= 1'b0;
            iff_q      <= 1'b0;
        end else begin
            last_rdy_q <= last_rdy_d;
            iff_q      <= iff_d;
        end
    end

    assign req = iff_q | (sc & rdy);

endmodule

// File: rtl/rh_intr_arb.sv
// Multi-channel RH11 interrupt arbiter: one bus request, held vector, steered ack.
// Define RH_INTR_ROUNDROBIN_EN for rotating priority; default is fixed (lowest index wins).
module rh_intr_arb
    import rh_pkg::*;
#(
    parameter int              NCH     = 4,
    parameter int              VECW    = 8,
    parameter logic [VECW-1:0] VECBASE = VECW'(RH_VEC_DEFAULT),
    parameter int              VECSTEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            devRESET,
    input  logic            devLOBYTE,
    input  logic            wrRDY,
    input  logic            wrIE,
    input  logic [NCH-1:0]  cs1WRITE,
    input  logic [NCH-1:0]  chRDY,
    input  logic [NCH-1:0]  chIE,
    input  logic [NCH-1:0]  chSC,
    input  logic [NCH-1:0]  chCLR,
    input  logic            iack,
    output logic            irq,
    output logic [VECW-1:0] irqVECT,
    output logic [NCH-1:0]  ackCH,
    output logic [NCH-1:0]  pend
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    rh_state_e       state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [VECW-1:0] vect_q, vect_d;
    logic [GW-1:0]   win;
    logic            win_vld;
    logic [NCH-1:0]  req;
    logic [NCH-1:0]  ack_vec;
    logic            wr_qual;

    function automatic logic [VECW-1:0] vec_of(input logic [GW-1:0] ch);
        logic [31:0] v;
        v = 32'(VECBASE) + 32'(VECSTEP) * 32'(ch);
        return v[VECW-1:0];
    endfunction

    assign wr_qual = devLOBYTE & wrRDY & wrIE;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        rh_intr_chan u_chan (
            .clk       (clk),
            .rst       (rst),
            .dev_reset (devRESET),
            .wr_set    (cs1WRITE[i] & wr_qual),
            .rdy       (chRDY[i]),
            .ie        (chIE[i]),
            .sc        (chSC[i]),
            .clr       (chCLR[i]),
            .ack       (ack_vec[i]),
            .req       (req[i])
        );
    end

`ifdef RH_INTR_ROUNDROBIN_EN
    logic [GW-1:0] ptr_q, ptr_d;

    // Search starts at the channel after the last acknowledged one.
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_vld = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr_q) + k) % NCH;
            if (!win_vld && req[idx]) begin
                win     = GW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_REQ && iack) begin
            ptr_d = (int'(gnt_q) == NCH - 1) ? '0 : gnt_q + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req[k]) begin
                win     = GW'(k);
                win_vld = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            vect_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            vect_q  <= vect_d;
        end
    end

    // iack beats a simultaneous withdrawal: the vector is already on the bus.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        vect_d  = vect_q;
        if (devRESET) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_vld) begin
                        state_d = ST_REQ;
                        gnt_d   = win;
                        vect_d  = vec_of(win);
                    end
                end
                ST_REQ: begin
                    if (iack) begin
                        state_d = ST_ACK;
                    end else if (!req[gnt_q]) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACK:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        irq     = (state_q == ST_REQ);
        ack_vec = '0;
        if (state_q == ST_REQ && iack) begin
            ack_vec[gnt_q] = 1'b1;
        end
    end

    assign ackCH   = ack_vec;
    assign pend    = req;
    assign irqVECT = vect_q;

endmodule

// File: tb/tb_rh_intr_arb.sv
// Bench for rh_intr_arb: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the interrupt rules.
module tb_rh_intr_arb;

    localparam int NCH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       devRESET, devLOBYTE, wrRDY, wrIE, iack;
    logic [3:0] cs1WRITE, chRDY, chIE, chSC, chCLR;
    logic       irq;
    logic [7:0] irqVECT;
    logic [3:0] ackCH, pend;

    int total = 0;
    int bad   = 0;

    logic [3:0] s_ack, s_pend;

    // Behavioural model state
    bit         m_iff  [NCH];
    bit         m_last [NCH];
    bit         m_irq, m_gap;
    int         m_gnt, m_ptr;
    logic [7:0] m_vect;

    rh_intr_arb #(.NCH(4), .VECW(8), .VECBASE(8'o254), .VECSTEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .devRESET  (devRESET),
        .devLOBYTE (devLOBYTE),
        .wrRDY     (wrRDY),
        .wrIE      (wrIE),
        .cs1WRITE  (cs1WRITE),
        .chRDY     (chRDY),
        .chIE      (chIE),
        .chSC      (chSC),
        .chCLR     (chCLR),
        .iack      (iack),
        .irq       (irq),
        .irqVECT   (irqVECT),
        .ackCH     (ackCH),
        .pend      (pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_req(input int i);
        return m_iff[i] | (chSC[i] & chRDY[i]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_iff[i]  = 1'b0;
            m_last[i] = 1'b0;
        end
        m_irq  = 1'b0;
        m_gap  = 1'b0;
        m_gnt  = 0;
        m_ptr  = 0;
        m_vect = 8'h00;
    endtask

    task automatic model_clock();
        bit r [NCH];
        int ackc;
        int w;
        int c;
        bit set_ev, clr_ev;
        for (int i = 0; i < NCH; i++) r[i] = m_req(i);
        ackc = (m_irq && iack) ? m_gnt : -1;
        for (int i = 0; i < NCH; i++) begin
            set_ev = (chRDY[i] && !m_last[i] && chIE[i]) ||
                     (cs1WRITE[i] && devLOBYTE && wrRDY && wrIE);
            clr_ev = devRESET || chCLR[i] || (ackc == i);
            if (clr_ev) m_iff[i] = 1'b0;
            else if (set_ev) m_iff[i] = 1'b1;
            m_last[i] = chRDY[i];
        end
        if (ackc >= 0) m_ptr = (m_gnt + 1) % NCH;
        if (devRESET) begin
            m_irq = 1'b0;
            m_gap = 1'b0;
        end else if (m_irq) begin
            if (iack) begin
                m_irq = 1'b0;
                m_gap = 1'b1;
            end else if (!r[m_gnt]) begin
                m_irq = 1'b0;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            w = -1;
            for (int k = 0; k < NCH; k++) begin
`ifdef RH_INTR_ROUNDROBIN_EN
                c = (m_ptr + k) % NCH;
`else
                c = k;
`endif
                if (w < 0 && r[c]) w = c;
            end
            if (w >= 0) begin
                m_irq  = 1'b1;
                m_gnt  = w;
                m_vect = 8'((172 + 4 * w) % 256);
            end
        end
    endtask

    // Called just after a rising edge with inputs already driven.
    task automatic step(input string tag);
        logic [3:0] ep, ea;
        @(negedge clk);
        for (int i = 0; i < NCH; i++) ep[i] = m_req(i);
        ea = (m_irq && iack) ? 4'(1 << m_gnt) : 4'b0000;
        s_ack  = ackCH;
        s_pend = pend;
        check({tag, "_irq"},  32'(irq),   32'(m_irq));
        check({tag, "_pend"}, 32'(pend),  32'(ep));
        check({tag, "_ack"},  32'(ackCH), 32'(ea));
        if (m_irq) check({tag, "_vec"}, 32'(irqVECT), 32'(m_vect));
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        devRESET  = 1'b0;
        devLOBYTE = 1'b0;
        wrRDY     = 1'b0;
        wrIE      = 1'b0;
        iack      = 1'b0;
        cs1WRITE  = 4'b0000;
        chRDY     = 4'b0000;
        chIE      = 4'b0000;
        chSC      = 4'b0000;
        chCLR     = 4'b0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_cs1(input logic [3:0] mask);
        cs1WRITE  = mask;
        devLOBYTE = 1'b1;
        wrRDY     = 1'b1;
        wrIE      = 1'b1;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_vec", 32'(irqVECT), 32'd0);
        check("rst_ack", 32'(ackCH), 32'd0);

        // ch2 RDY edge with IE set
        chIE = 4'b0100;
        step("t1a");
        chRDY = 4'b0100;
        step("t1b");
        check("t1_irq_lat", 32'(irq), 32'd0);
        step("t1c");
        check("t1_irq", 32'(irq), 32'd1);
        check("t1_vec", 32'(irqVECT), 32'(8'o264));
        iack = 1'b1;
        step("t1d");
        check("t1_ackch", 32'(s_ack), 32'(4'b0100));
        check("t1_gap0", 32'(irq), 32'd0);
        iack = 1'b0;
        step("t1e");
        check("t1_gap1", 32'(irq), 32'd0);
        idle_inputs();
        step("t1f");

        // ch0 requested by a CS1 low-byte write with RDY already high
        chRDY = 4'b0001;
        step("t2a");
        write_cs1(4'b0001);
        step("t2b");
        idle_inputs();
        chRDY = 4'b0001;
        step("t2c");
        check("t2_irq", 32'(irq), 32'd1);
        check("t2_vec", 32'(irqVECT), 32'(8'o254));
        iack = 1'b1;
        step("t2d");
        check("t2_ackch", 32'(s_ack), 32'(4'b0001));
        idle_inputs();
        step("t2e");

        // ch1 level SC&RDY request then withdrawal
        chRDY = 4'b0010;
        chSC  = 4'b0010;
        step("t3a");
        check("t3_irq", 32'(irq), 32'd1);
        check("t3_vec", 32'(irqVECT), 32'(8'o260));
        chSC = 4'b0000;
        step("t3b");
        check("t3_noack", 32'(s_ack), 32'd0);
        check("t3_drop", 32'(irq), 32'd0);
        step("t3c");
        check("t3_pend", 32'(s_pend), 32'd0);
        idle_inputs();
        step("t3d");

        // ch0 and ch3 pending together
        do_reset();
        write_cs1(4'b1001);
        step("t4a");
        idle_inputs();
        step("t4b");
        check("t4_vec0", 32'(irqVECT), 32'(8'o254));
        iack = 1'b1;
        step("t4c");
        iack = 1'b0;
        step("t4d");
        step("t4e");
        check("t4_irq3", 32'(irq), 32'd1);
        check("t4_vec3", 32'(irqVECT), 32'(8'o270));
        iack = 1'b1;
        step("t4f");
        check("t4_ackch3", 32'(s_ack), 32'(4'b1000));
        iack = 1'b0;
        step("t4g");
        write_cs1(4'b1001);
        step("t4h");
        idle_inputs();
        step("t4i");
        check("t4_vec0b", 32'(irqVECT), 32'(8'o254));
        for (int n = 0; n < 2; n++) begin
            iack = 1'b1;
            step("t4j");
            iack = 1'b0;
            step("t4k");
            step("t4l");
        end

        // iack together with chCLR of the granted channel
        write_cs1(4'b0100);
        step("t5a");
        idle_inputs();
        step("t5b");
        check("t5_vec", 32'(irqVECT), 32'(8'o264));
        iack  = 1'b1;
        chCLR = 4'b0100;
        step("t5c");
        check("t5_ackch", 32'(s_ack), 32'(4'b0100));
        idle_inputs();
        step("t5d");
        step("t5e");
        check("t5_noreq", 32'(irq), 32'd0);
        check("t5_pend", 32'(s_pend), 32'd0);

        // devRESET while in REQ with three channels pending
        write_cs1(4'b0111);
        step("t6a");
        idle_inputs();
        step("t6b");
        check("t6_irq", 32'(irq), 32'd1);
        devRESET = 1'b1;
        step("t6c");
        check("t6_irq_off", 32'(irq), 32'd0);
        devRESET = 1'b0;
        step("t6d");
        check("t6_pend", 32'(s_pend), 32'd0);
        check("t6_idle", 32'(irq), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) chRDY = chRDY ^ 4'($urandom);
            chIE      = 4'($urandom);
            chSC      = ($urandom_range(0, 5) == 0) ? 4'($urandom & $urandom) : 4'b0000;
            chCLR     = ($urandom_range(0, 9) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            cs1WRITE  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            devLOBYTE = ($urandom_range(0, 3) != 0);
            wrRDY     = ($urandom_range(0, 3) != 0);
            wrIE      = ($urandom_range(0, 3) != 0);
            iack      = ($urandom_range(0, 2) == 0);
            devRESET  = ($urandom_range(0, 59) == 0);
            if (devRESET) iack = 1'b0;
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
